// File: rtl/threshold_setup_controller.sv
// Threshold programming front end: synchronises and debounces the save buttons, waits for the switch bank
// to settle, validates the request and emits one pre-validated save strobe or a timed reject.
module threshold_setup_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES   = 2_000_000,
  parameter int ERR_CYCLES      = 50_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_high_raw,
  input  logic       btn_low_raw,
  input  logic [7:0] setup_raw,
  input  logic [7:0] high_threshold,
  input  logic [7:0] low_threshold,
  output logic       save_high,
  output logic       save_low,
  output logic [7:0] setup_out,
  output logic       busy,
  output logic       reject,
  output logic [1:0] error_code,
  output logic       error_led,
  output logic [2:0] dbg_state_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);
  localparam int ER_W = $clog2(ERR_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_MAX  = ST_W'(SETTLE_CYCLES);
  localparam logic [ER_W-1:0] ER_MAX  = ER_W'(ERR_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHECK    = 3'd1,
    S_COMMIT   = 3'd2,
    S_ERROR    = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  // Button vectors: bit 1 = save-high, bit 0 = save-low.
  logic [1:0]      btn_s1_q, btn_s2_q, btn_db_q, btn_db_prev_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic [7:0]      sw_s1_q, sw_s2_q, sw_prev_q;
  logic [ST_W-1:0] settle_cnt_q;
  logic            stable;
  logic [1:0]      btn_rise;

  state_t          state_q, state_d;
  logic            req_high_q, req_high_d;
  logic [7:0]      setup_q, setup_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [ER_W-1:0] err_tmr_q, err_tmr_d;
  logic [8:0]      dec;
  logic [1:0]      chk_code;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sw_prev_q <= '0;
    end else begin
      btn_s1_q  <= {btn_high_raw, btn_low_raw};
      btn_s2_q  <= btn_s1_q;
      sw_s1_q   <= setup_raw;
      sw_s2_q   <= sw_s1_q;
      sw_prev_q <= sw_s2_q;
    end
  end

  // The debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
      btn_db_q      <= '0;
      btn_db_prev_q <= '0;
    end else begin
      btn_db_prev_q <= btn_db_q;
      for (int b = 0; b < 2; b++) begin
        if (btn_s2_q[b] == btn_db_q[b]) begin
          db_cnt_q[b] <= '0;
        end else if (db_cnt_q[b] == DB_LAST) begin
          db_cnt_q[b] <= '0;
          btn_db_q[b] <= ~btn_db_q[b];
        end else begin
          db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      settle_cnt_q <= '0;
    end else if (sw_s2_q != sw_prev_q) begin
      settle_cnt_q <= '0;
    end else if (settle_cnt_q != ST_MAX) begin
      settle_cnt_q <= settle_cnt_q + 1'b1;
    end
  end

  assign stable   = (settle_cnt_q == ST_MAX);
  assign btn_rise = btn_db_q & ~btn_db_prev_q;

  // Returns {valid, percent}.
  function automatic logic [8:0] decode(input logic [7:0] code);
    case (code)
      8'h00:   decode = {1'b1, 8'd0};
      8'h01:   decode = {1'b1, 8'd12};
      8'h03:   decode = {1'b1, 8'd25};
      8'h07:   decode = {1'b1, 8'd38};
      8'h0F:   decode = {1'b1, 8'd50};
      8'h1F:   decode = {1'b1, 8'd63};
      8'h3F:   decode = {1'b1, 8'd75};
      8'h7F:   decode = {1'b1, 8'd88};
      8'hFF:   decode = {1'b1, 8'd100};
      default: decode = {1'b0, 8'd0};
    endcase
  endfunction

  always_comb begin
    dec      = decode(setup_q);
    chk_code = 2'd0;
    if ((btn_db_q[1] & btn_db_q[0]) | ~stable) begin
      chk_code = 2'd3;
    end else if (!dec[8]) begin
      chk_code = 2'd1;
    end else if (req_high_q ? (dec[7:0] <= low_threshold) : (dec[7:0] >= high_threshold)) begin
      chk_code = 2'd2;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_high_d = req_high_q;
    setup_d    = setup_q;
    err_code_d = err_code_q;
    err_tmr_d  = (err_tmr_q != '0) ? err_tmr_q - 1'b1 : err_tmr_q;
    case (state_q)
      S_IDLE: begin
        if (|btn_rise) begin
          state_d    = S_CHECK;
          req_high_d = btn_rise[1];
          setup_d    = sw_s2_q;
        end
      end
      S_CHECK: begin
        err_code_d = chk_code;
        state_d    = (chk_code == 2'd0) ? S_COMMIT : S_ERROR;
      end
      S_COMMIT: state_d = S_WAIT_REL;
      S_ERROR: begin
        err_tmr_d = ER_MAX;
        state_d   = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (btn_db_q == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      req_high_q <= 1'b0;
      setup_q    <= '0;
      err_code_q <= '0;
      err_tmr_q  <= '0;
    end else begin
      state_q    <= state_d;
      req_high_q <= req_high_d;
      setup_q    <= setup_d;
      err_code_q <= err_code_d;
      err_tmr_q  <= err_tmr_d;
    end
  end

  // Strobes decode straight from state so an asynchronous reset kills them in the same cycle.
  assign save_high   = (state_q == S_COMMIT) &  req_high_q;
  assign save_low    = (state_q == S_COMMIT) & ~req_high_q;
  assign reject      = (state_q == S_ERROR);
  assign busy        = (state_q != S_IDLE);
  assign setup_out   = setup_q;
  assign error_code  = err_code_q;
  assign error_led   = (err_tmr_q != '0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_threshold_setup_controller.sv
// Bench for threshold_setup_controller: table-driven presses, hand-written corner sequences
// and randomized presses checked against a percent/threshold reference model.
module tb_threshold_setup_controller;

  localparam int DB = 4;
  localparam int ST = 8;
  localparam int ER = 16;
  // Raw press to strobe: 2 sync + DB debounce + CHECK + COMMIT/ERROR.
  localparam int PRESS_LAT = 2 + DB + 2;

  logic       clk_100MHz = 1'b0;
  logic       reset = 1'b1;
  logic       btn_high_raw = 1'b0;
  logic       btn_low_raw = 1'b0;
  logic [7:0] setup_raw = 8'h00;
  logic [7:0] high_threshold = 8'd100;
  logic [7:0] low_threshold = 8'd0;
  logic       save_high, save_low, busy, reject, error_led;
  logic [7:0] setup_out;
  logic [1:0] error_code;
  logic [2:0] dbg_state_o;

  always #5 clk_100MHz = ~clk_100MHz;

  threshold_setup_controller #(
    .DEBOUNCE_CYCLES(DB), .SETTLE_CYCLES(ST), .ERR_CYCLES(ER)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .btn_high_raw(btn_high_raw), .btn_low_raw(btn_low_raw),
    .setup_raw(setup_raw), .high_threshold(high_threshold), .low_threshold(low_threshold),
    .save_high(save_high), .save_low(save_low), .setup_out(setup_out),
    .busy(busy), .reject(reject), .error_code(error_code), .error_led(error_led),
    .dbg_state_o(dbg_state_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int sh_cnt = 0;
  int sl_cnt = 0;
  int rj_cnt = 0;

  typedef struct {
    logic [7:0] sw;
    bit         hi;
    logic [7:0] lo_t;
    logic [7:0] hi_t;
    logic [1:0] code;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: thermometer code -> level index by counting, then the percent table and ordering rules.
  function automatic logic [1:0] model_code(input logic [7:0] sw, input bit hi, input int lo_t, input int hi_t);
    int pct_tab [9];
    int idx;
    pct_tab = '{0, 12, 25, 38, 50, 63, 75, 88, 100};
    idx = -1;
    for (int k = 0; k <= 8; k++) if (int'(sw) == (1 << k) - 1) idx = k;
    if (idx < 0) return 2'd1;
    if (hi && pct_tab[idx] <= lo_t) return 2'd2;
    if (!hi && pct_tab[idx] >= hi_t) return 2'd2;
    return 2'd0;
  endfunction

  always @(negedge clk_100MHz) begin
    if (!reset) begin
      if (save_high) sh_cnt++;
      if (save_low) sl_cnt++;
      if (reject) rj_cnt++;
      if (save_high | save_low | reject)
        check("strobe_exclusive", int'(save_high) + int'(save_low) + int'(reject), 1);
    end
  end

  task automatic wait_result(input string tag, input int exp_lat, input logic [1:0] exp_code,
                             input bit exp_sh, input bit exp_sl, input bit exp_rj, input logic [7:0] exp_sw);
    int lat;
    bit seen;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge clk_100MHz);
      lat++;
      @(negedge clk_100MHz);
      if (save_high | save_low | reject) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_save_high"}, save_high, exp_sh);
      check({tag, "_save_low"}, save_low, exp_sl);
      check({tag, "_reject"}, reject, exp_rj);
      check({tag, "_error_code"}, error_code, exp_code);
      check({tag, "_setup_out"}, setup_out, exp_sw);
    end
  endtask

  task automatic finish_press(input string tag, input int hold, input logic [1:0] exp_code,
                              input bit exp_sh, input bit exp_sl, input bit exp_rj);
    int led;
    int w;
    led = 0;
    w = 0;
    repeat (hold) begin
      @(negedge clk_100MHz);
      if (error_led) led++;
    end
    check({tag, "_led_cycles"}, led, exp_rj ? ER : 0);
    btn_high_raw = 1'b0;
    btn_low_raw = 1'b0;
    while (busy && w < 60) begin
      @(negedge clk_100MHz);
      w++;
    end
    check({tag, "_back_idle"}, busy, 0);
    check({tag, "_total_save_high"}, sh_cnt, exp_sh);
    check({tag, "_total_save_low"}, sl_cnt, exp_sl);
    check({tag, "_total_reject"}, rj_cnt, exp_rj);
    check({tag, "_code_held"}, error_code, exp_code);
  endtask

  task automatic setup_and_settle(input logic [7:0] sw, input logic [7:0] lo_t, input logic [7:0] hi_t);
    low_threshold = lo_t;
    high_threshold = hi_t;
    setup_raw = sw;
    repeat (20) @(posedge clk_100MHz);
    #1;
    sh_cnt = 0;
    sl_cnt = 0;
    rj_cnt = 0;
  endtask

  task automatic run_press(input string tag, input logic [7:0] sw, input bit hi, input logic [7:0] lo_t,
                           input logic [7:0] hi_t, input logic [1:0] code, input int hold);
    bit exp_sh, exp_sl, exp_rj;
    exp_sh = hi && (code == 2'd0);
    exp_sl = !hi && (code == 2'd0);
    exp_rj = (code != 2'd0);
    setup_and_settle(sw, lo_t, hi_t);
    if (hi) btn_high_raw = 1'b1;
    else btn_low_raw = 1'b1;
    wait_result(tag, PRESS_LAT, code, exp_sh, exp_sl, exp_rj, sw);
    finish_press(tag, hold, code, exp_sh, exp_sl, exp_rj);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r_sw, r_lo, r_hi;
    bit r_hi_req;

    vecs[0] = '{8'h0F, 1'b1, 8'd0,  8'd100, 2'd0};
    vecs[1] = '{8'h05, 1'b0, 8'd0,  8'd100, 2'd1};
    vecs[2] = '{8'h0F, 1'b1, 8'd50, 8'd100, 2'd2};
    vecs[3] = '{8'h1F, 1'b1, 8'd50, 8'd100, 2'd0};
    vecs[4] = '{8'hFF, 1'b0, 8'd0,  8'd100, 2'd2};
    vecs[5] = '{8'h00, 1'b0, 8'd0,  8'd100, 2'd0};
    vecs[6] = '{8'h00, 1'b1, 8'd0,  8'd100, 2'd2};
    vecs[7] = '{8'h7F, 1'b0, 8'd10, 8'd90,  2'd0};
    vecs[8] = '{8'h80, 1'b1, 8'd0,  8'd100, 2'd1};

    repeat (3) @(negedge clk_100MHz);
    check("rst_save_high", save_high, 0);
    check("rst_save_low", save_low, 0);
    check("rst_reject", reject, 0);
    check("rst_busy", busy, 0);
    check("rst_setup_out", setup_out, 0);
    check("rst_error_code", error_code, 0);
    check("rst_error_led", error_led, 0);
    check("rst_state", dbg_state_o, 0);
    reset = 1'b0;

    // Long hold on the first vector: still only one strobe.
    run_press("hold200", vecs[0].sw, vecs[0].hi, vecs[0].lo_t, vecs[0].hi_t, vecs[0].code, 200);
    for (int i = 1; i < 9; i++)
      run_press($sformatf("vec%0d", i), vecs[i].sw, vecs[i].hi, vecs[i].lo_t, vecs[i].hi_t, vecs[i].code, 24);

    // Bouncing button: no strobe during the bounce, one strobe measured from the steady level.
    setup_and_settle(8'h0F, 8'd0, 8'd100);
    for (int i = 0; i < 30; i++) begin
      btn_high_raw = (i % 2 == 0);
      @(posedge clk_100MHz);
      #1;
    end
    btn_high_raw = 1'b1;
    wait_result("bounce", PRESS_LAT, 2'd0, 1'b1, 1'b0, 1'b0, 8'h0F);
    finish_press("bounce", 24, 2'd0, 1'b1, 1'b0, 1'b0);

    // Both buttons together.
    setup_and_settle(8'h0F, 8'd0, 8'd100);
    btn_high_raw = 1'b1;
    btn_low_raw = 1'b1;
    wait_result("both", PRESS_LAT, 2'd3, 1'b0, 1'b0, 1'b1, 8'h0F);
    finish_press("both", 24, 2'd3, 1'b0, 1'b0, 1'b1);

    // Switches move 3 cycles before the debounced edge.
    setup_and_settle(8'h0F, 8'd0, 8'd100);
    btn_high_raw = 1'b1;
    repeat (3) @(posedge clk_100MHz);
    #1;
    setup_raw = 8'h1F;
    wait_result("unsettled", PRESS_LAT - 3, 2'd3, 1'b0, 1'b0, 1'b1, 8'h1F);
    finish_press("unsettled", 24, 2'd3, 1'b0, 1'b0, 1'b1);

    // Reset in the CHECK cycle.
    setup_and_settle(8'h0F, 8'd0, 8'd100);
    btn_high_raw = 1'b1;
    repeat (PRESS_LAT - 1) @(posedge clk_100MHz);
    @(negedge clk_100MHz);
    check("midrst_busy_in_check", busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_save_high", save_high, 0);
    check("midrst_save_low", save_low, 0);
    check("midrst_reject", reject, 0);
    check("midrst_busy", busy, 0);
    check("midrst_setup_out", setup_out, 0);
    check("midrst_error_code", error_code, 0);
    check("midrst_error_led", error_led, 0);
    check("midrst_state", dbg_state_o, 0);
    btn_high_raw = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (30) @(negedge clk_100MHz);
    check("midrst_no_save", sh_cnt + sl_cnt, 0);
    check("midrst_no_reject", rj_cnt, 0);
    check("midrst_idle", busy, 0);
    run_press("after_reset", 8'h0F, 1'b1, 8'd0, 8'd100, 2'd0, 24);

    // Randomized presses against the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) r_sw = 8'((1 << $urandom_range(0, 8)) - 1);
      else r_sw = 8'($urandom);
      r_hi_req = 1'($urandom_range(0, 1));
      r_lo = 8'($urandom_range(0, 100));
      r_hi = 8'($urandom_range(0, 100));
      run_press($sformatf("rand%0d", i), r_sw, r_hi_req, r_lo, r_hi,
                model_code(r_sw, r_hi_req, int'(r_lo), int'(r_hi)), 24);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
